// File: rtl/matrix_fifo_ctrl.sv
// Load/drain sequencer for an N x N matrix-element FIFO: accepts N*N elements, then emits them row-major with indices.
// Optional abort/flush path is compiled in with `define CTRL_ABORT_EN.
module matrix_fifo_ctrl #(
    parameter int N_MAX = 8,
    parameter int CNT_W = $clog2(N_MAX*N_MAX)+1,
    parameter int IDX_W = $clog2(N_MAX)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_fifo_push,
    output logic             o_fifo_pop,
    input  logic             i_fifo_full,
    input  logic             i_fifo_empty,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [IDX_W-1:0] o_row_idx,
    output logic [IDX_W-1:0] o_col_idx,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
`ifdef CTRL_ABORT_EN
    ,
    input  logic             i_abort,
    output logic             o_fifo_flush
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]       r_state;
    logic [3:0]       r_n_q;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;

    logic [2:0]       w_state_nxt;
    logic [3:0]       w_n_q_nxt;
    logic [CNT_W-1:0] w_total_nxt;
    logic [CNT_W-1:0] w_load_cnt_nxt;
    logic [CNT_W-1:0] w_drain_cnt_nxt;
    logic [IDX_W-1:0] w_row_nxt;
    logic [IDX_W-1:0] w_col_nxt;

    logic             w_n_ok;
    logic [CNT_W-1:0] w_n_ext;
    logic             w_in_ready;
    logic             w_push;
    logic             w_out_valid;
    logic             w_pop;
    logic             w_last;
    logic             w_col_wrap;

`ifdef CTRL_ABORT_EN
    logic             r_flush;
    logic             w_flush_nxt;
`endif

    assign w_n_ok     = (i_n != 4'd0) && (32'(i_n) <= 32'(N_MAX));
    assign w_n_ext    = CNT_W'(i_n);
    assign w_col_wrap = (CNT_W'(r_col) == (CNT_W'(r_n_q) - CNT_W'(1)));

    // Zero-cycle handshakes; LOAD and DRAIN are exclusive so push and pop never coincide.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        if (r_state == S_LOAD) begin
            w_in_ready = !i_fifo_full && (r_load_cnt < r_total);
        end else if (r_state == S_DRAIN) begin
            w_out_valid = !i_fifo_empty;
        end else begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
        end
        w_push = i_in_valid && w_in_ready;
        w_pop  = w_out_valid && i_out_ready;
        w_last = w_out_valid && (r_drain_cnt == (r_total - CNT_W'(1)));
    end

    // Next-state and counter update logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_n_q_nxt       = r_n_q;
        w_total_nxt     = r_total;
        w_load_cnt_nxt  = r_load_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
`ifdef CTRL_ABORT_EN
        w_flush_nxt     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_n_ok) begin
                        w_n_q_nxt      = i_n;
                        w_total_nxt    = w_n_ext * w_n_ext;
                        w_load_cnt_nxt = {CNT_W{1'b0}};
                        w_state_nxt    = S_LOAD;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_push) begin
                    w_load_cnt_nxt = r_load_cnt + CNT_W'(1);
                    if ((r_load_cnt + CNT_W'(1)) == r_total) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (w_pop) begin
                    w_drain_cnt_nxt = r_drain_cnt + CNT_W'(1);
                    if (w_col_wrap) begin
                        w_col_nxt = {IDX_W{1'b0}};
                        w_row_nxt = r_row + IDX_W'(1);
                    end else begin
                        w_col_nxt = r_col + IDX_W'(1);
                    end
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_n_q_nxt       = 4'd0;
                w_total_nxt     = {CNT_W{1'b0}};
                w_load_cnt_nxt  = {CNT_W{1'b0}};
                w_drain_cnt_nxt = {CNT_W{1'b0}};
                w_row_nxt       = {IDX_W{1'b0}};
                w_col_nxt       = {IDX_W{1'b0}};
                w_state_nxt     = S_IDLE;
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_n_q_nxt       = 4'd0;
                w_total_nxt     = {CNT_W{1'b0}};
                w_load_cnt_nxt  = {CNT_W{1'b0}};
                w_drain_cnt_nxt = {CNT_W{1'b0}};
                w_row_nxt       = {IDX_W{1'b0}};
                w_col_nxt       = {IDX_W{1'b0}};
                w_state_nxt     = S_IDLE;
            end
        endcase
`ifdef CTRL_ABORT_EN
        // Abort overrides any in-flight transfer; FIFO contents are discarded via the flush pulse.
        if (i_abort && ((r_state == S_LOAD) || (r_state == S_DRAIN))) begin
            w_n_q_nxt       = 4'd0;
            w_total_nxt     = {CNT_W{1'b0}};
            w_load_cnt_nxt  = {CNT_W{1'b0}};
            w_drain_cnt_nxt = {CNT_W{1'b0}};
            w_row_nxt       = {IDX_W{1'b0}};
            w_col_nxt       = {IDX_W{1'b0}};
            w_state_nxt     = S_IDLE;
            w_flush_nxt     = 1'b1;
        end else begin
            w_flush_nxt     = 1'b0;
        end
`endif
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_n_q       <= 4'd0;
            r_total     <= {CNT_W{1'b0}};
            r_load_cnt  <= {CNT_W{1'b0}};
            r_drain_cnt <= {CNT_W{1'b0}};
            r_row       <= {IDX_W{1'b0}};
            r_col       <= {IDX_W{1'b0}};
`ifdef CTRL_ABORT_EN
            r_flush     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_n_q       <= w_n_q_nxt;
            r_total     <= w_total_nxt;
            r_load_cnt  <= w_load_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
`ifdef CTRL_ABORT_EN
            r_flush     <= w_flush_nxt;
`endif
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_fifo_push = w_push;
    assign o_out_valid = w_out_valid;
    assign o_fifo_pop  = w_pop;
    assign o_last      = w_last;
    assign o_row_idx   = r_row;
    assign o_col_idx   = r_col;
    assign o_busy      = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign o_done      = (r_state == S_DONE);
    assign o_error     = (r_state == S_ERR);
`ifdef CTRL_ABORT_EN
    assign o_fifo_flush = r_flush;
`endif

endmodule

// File: tb/tb_matrix_fifo_ctrl.sv
// Directed self-checking bench for matrix_fifo_ctrl; abort scenario compiled when CTRL_ABORT_EN is defined.
module tb_matrix_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] n = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] row_idx;
    logic [2:0] col_idx;
    logic       last;
    logic       busy;
    logic       done;
    logic       error;
`ifdef CTRL_ABORT_EN
    logic       abort = 1'b0;
    logic       fifo_flush;
`endif

    logic       force_full = 1'b0;
    logic       force_empty = 1'b0;
    int         occ = 0;
    int         push_cnt = 0;
    int         pop_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    matrix_fifo_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_n          (n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_fifo_push  (fifo_push),
        .o_fifo_pop   (fifo_pop),
        .i_fifo_full  (fifo_full),
        .i_fifo_empty (fifo_empty),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_row_idx    (row_idx),
        .o_col_idx    (col_idx),
        .o_last       (last),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error)
`ifdef CTRL_ABORT_EN
        ,
        .i_abort      (abort),
        .o_fifo_flush (fifo_flush)
`endif
    );

    // Simple 16-deep FIFO occupancy model feeding the flags.
    assign fifo_full  = force_full  || (occ >= 16);
    assign fifo_empty = force_empty || (occ == 0);

    always @(posedge clk) begin
`ifdef CTRL_ABORT_EN
        if (fifo_flush) occ <= 0;
        else            occ <= occ + int'(fifo_push) - int'(fifo_pop);
`else
        occ <= occ + int'(fifo_push) - int'(fifo_pop);
`endif
        if (fifo_push) push_cnt <= push_cnt + 1;
        if (fifo_pop)  pop_cnt  <= pop_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] all_outs();
        return {in_ready, fifo_push, fifo_pop, out_valid, row_idx, col_idx, last, busy, done, error};
    endfunction

    initial begin
        int base_push;
        int base_pop;
        int e;

        // ---- reset ----
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_outs", 32'(all_outs()), 32'd0);

        // ---- n=3 full stream ----
        start = 1'b1; n = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("t1_idle_busy", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        base_push = push_cnt;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("t1_in_ready", 32'(in_ready), 32'd1);
            chk("t1_push", 32'(fifo_push), 32'd1);
            chk("t1_busy_load", 32'(busy), 32'd1);
            step();
        end
        chk("t1_push_total", 32'(push_cnt - base_push), 32'd9);
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("t1_pop", 32'(fifo_pop), 32'd1);
            chk("t1_row", 32'(row_idx), 32'(k / 3));
            chk("t1_col", 32'(col_idx), 32'(k % 3));
            chk("t1_last", 32'(last), (k == 8) ? 32'd1 : 32'd0);
            chk("t1_push_in_drain", 32'(fifo_push), 32'd0);
            step();
        end
        #1;
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);
        step();
        #1;
        chk("t1_done_pulse", 32'(done), 32'd0);

        // ---- n=2 with fifo_full stall ----
        start = 1'b1; n = 4'd2;
        step();
        start = 1'b0;
        base_push = push_cnt;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t2_ready_pre", 32'(in_ready), 32'd1);
            step();
        end
        force_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_ready_stall", 32'(in_ready), 32'd0);
            chk("t2_push_stall", 32'(fifo_push), 32'd0);
            step();
        end
        force_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t2_ready_post", 32'(in_ready), 32'd1);
            step();
        end
        chk("t2_push_total", 32'(push_cnt - base_push), 32'd4);
        base_pop = pop_cnt;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_pop", 32'(fifo_pop), 32'd1);
            step();
        end
        #1;
        chk("t2_pop_total", 32'(pop_cnt - base_pop), 32'd4);
        chk("t2_done", 32'(done), 32'd1);
        step();

        // ---- n=2 drain with toggling out_ready and empty stall ----
        start = 1'b1; n = 4'd2; out_ready = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        base_pop = pop_cnt;
        e = 0;
        for (int c = 0; c < 20 && e < 4; c++) begin
            out_ready   = (c % 2 == 0);
            force_empty = (c == 3) || (c == 4);
            #1;
            chk("t3_valid", 32'(out_valid), force_empty ? 32'd0 : 32'd1);
            chk("t3_pop", 32'(fifo_pop), (!force_empty && out_ready) ? 32'd1 : 32'd0);
            chk("t3_row", 32'(row_idx), 32'(e / 2));
            chk("t3_col", 32'(col_idx), 32'(e % 2));
            chk("t3_last", 32'(last), (!force_empty && e == 3) ? 32'd1 : 32'd0);
            if (!force_empty && out_ready) e++;
            step();
        end
        force_empty = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_pop_total", 32'(pop_cnt - base_pop), 32'd4);
        chk("t3_done", 32'(done), 32'd1);
        step();

        // ---- illegal n ----
        base_push = push_cnt;
        base_pop  = pop_cnt;
        in_valid = 1'b1;
        start = 1'b1; n = 4'd0;
        step();
        start = 1'b0;
        #1;
        chk("t4_err_n0", 32'(error), 32'd1);
        chk("t4_busy_n0", 32'(busy), 32'd0);
        step();
        #1;
        chk("t4_err_pulse_n0", 32'(error), 32'd0);
        start = 1'b1; n = 4'd9;
        step();
        start = 1'b0;
        #1;
        chk("t4_err_n9", 32'(error), 32'd1);
        chk("t4_busy_n9", 32'(busy), 32'd0);
        step();
        #1;
        chk("t4_err_pulse_n9", 32'(error), 32'd0);
        chk("t4_no_push", 32'(push_cnt - base_push), 32'd0);
        chk("t4_no_pop", 32'(pop_cnt - base_pop), 32'd0);

        // ---- reset mid-LOAD, then n=1 ----
        start = 1'b1; n = 4'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #1;
        chk("t5_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_rst_outs", 32'(all_outs()), 32'd0);
        start = 1'b1; n = 4'd1;
        step();
        start = 1'b0;
        #1;
        chk("t5_push", 32'(fifo_push), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("t5_pop", 32'(fifo_pop), 32'd1);
        chk("t5_last", 32'(last), 32'd1);
        chk("t5_idx", 32'({row_idx, col_idx}), 32'd0);
        step();
        #1;
        chk("t5_done", 32'(done), 32'd1);
        step();

`ifdef CTRL_ABORT_EN
        // ---- abort during DRAIN ----
        in_valid = 1'b1;
        start = 1'b1; n = 4'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        for (int k = 0; k < 2; k++) step();
        out_ready = 1'b0;
        abort = 1'b1;
        #1;
        chk("t6_busy_pre_abort", 32'(busy), 32'd1);
        step();
        abort = 1'b0;
        #1;
        chk("t6_flush", 32'(fifo_flush), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_no_done", 32'(done), 32'd0);
        step();
        #1;
        chk("t6_flush_pulse", 32'(fifo_flush), 32'd0);
        chk("t6_no_done2", 32'(done), 32'd0);
        out_ready = 1'b1;
        base_push = push_cnt;
        base_pop  = pop_cnt;
        start = 1'b1; n = 4'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        for (int k = 0; k < 4; k++) step();
        #1;
        chk("t6_push_total", 32'(push_cnt - base_push), 32'd4);
        chk("t6_pop_total", 32'(pop_cnt - base_pop), 32'd4);
        chk("t6_done", 32'(done), 32'd1);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
